aes256_key_expand: RTL and testbench

Sequential AES-256 key schedule that turns a 256-bit cipher key into the 15 round keys (rounds 0..14), one 128-bit key per handshake. It sits directly upstream of the round-key XOR stage: `roundkey` from this block is that stage's `roundkey` operand. `rk_round` tags each key so the round controller can pair it with the matching state.

---
 rtl/aes256_pkg.sv | 14 +
 rtl/aes256_sbox.sv | 21 ++
 rtl/aes256_key_expand.sv | 79 +++++++
 tb/tb_aes256_key_expand.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/aes256_pkg.sv
// aes256_pkg: shared AES-256 key-schedule types, constants and helpers.
// Provides word/byte typedefs, the expander FSM state type, NR/NK, the Rcon table
// and the RotWord helper.
package aes256_pkg;
    typedef logic [7:0] byte_t;
    typedef logic [31:0] word_t;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int NR = 14;
    localparam int NK = 8;
    localparam byte_t RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes256_sbox.sv
// aes256_sbox: combinational AES forward S-box for one byte.
// Ports: a - input byte; s - substituted byte.
module aes256_sbox
    import aes256_pkg::*;
(
    input  byte_t a,
    output byte_t s
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Entry 0 sits in the top byte, so the offset of entry a is 8*(255-a) = {~a, 3'b000}.
    assign s = SBOX[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes256_key_expand.sv
// aes256_key_expand: sequential AES-256 key schedule, one 128-bit round key per handshake.
// Ports: clk/rst_n (async active-low); start+key request an expansion; busy while running;
// rk_valid/rk_ready handshake roundkey tagged with rk_round; done pulses after round 14.
module aes256_key_expand
    import aes256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*NK-1:0]  key,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [3:0]        rk_round,
    output logic [127:0]      roundkey,
    output logic              done
);
    state_t state;
    logic [127:0] prev, cur;
    logic [3:0] r_next;
    logic even;
    word_t t_in, t_sub, t, n0, n1, n2, n3;

    // The window {prev, cur} holds rounds r-2 and r-1 when round r is being built.
    assign r_next = rk_round + 4'd1;
    assign even = rk_round[0];
    assign t_in = even ? rot_word(cur[31:0]) : cur[31:0];
    assign t = t_sub ^ (even ? {RCON[r_next[3:1]], 24'h0} : 32'h0);
    assign n0 = prev[127:96] ^ t;
    assign n1 = prev[95:64] ^ n0;
    assign n2 = prev[63:32] ^ n1;
    assign n3 = prev[31:0] ^ n2;

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes256_sbox u_sbox (.a(t_in[8*i +: 8]), .s(t_sub[8*i +: 8]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            rk_valid <= 1'b0;
            done <= 1'b0;
            rk_round <= 4'd0;
            roundkey <= '0;
            prev <= '0;
            cur <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= RUN;
                    busy <= 1'b1;
                    rk_valid <= 1'b1;
                    prev <= key[255:128];
                    cur <= key[127:0];
                    roundkey <= key[255:128];
                    rk_round <= 4'd0;
                end
            end else if (rk_ready) begin
                if (rk_round == 4'(NR)) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    rk_valid <= 1'b0;
                    done <= 1'b1;
                end else if (rk_round == 4'd0) begin
                    // Round 1 is the second key half, already sitting in cur.
                    roundkey <= cur;
                    rk_round <= r_next;
                end else begin
                    prev <= cur;
                    cur <= {n0, n1, n2, n3};
                    roundkey <= {n0, n1, n2, n3};
                    rk_round <= r_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes256_key_expand.sv
// tb_aes256_key_expand: scoreboard bench for the AES-256 key expander.
module tb_aes256_key_expand;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [255:0] key = '0;
    logic rk_ready = 1'b1;
    logic busy, rk_valid, done;
    logic [3:0] rk_round;
    logic [127:0] roundkey;

    typedef struct {
        logic [3:0] round;
        logic [127:0] key;
        bit chk;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    bit stall_mode = 1'b0;
    bit done_pend = 1'b0;

    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3 [15] = '{
        128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
        128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
        128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
        128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
        128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
        128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
        128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
        128'hfe4890d1e6188d0b046df344706c631e
    };
    localparam logic [127:0] ZK [5] = '{
        128'h0, 128'h0,
        128'h62636363626363636263636362636363, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb,
        128'h6f6c6ccf0d0f0fac6f6c6ccf0d0f0fac
    };

    aes256_key_expand dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round),
        .roundkey(roundkey), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a3();
        for (int r = 0; r < 15; r++) q.push_back('{4'(r), A3[r], 1'b1});
    endtask

    task automatic push_zero();
        for (int r = 0; r < 15; r++) q.push_back('{4'(r), (r < 5) ? ZK[r] : 128'h0, r < 5});
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", lim);
        end
    endtask

    task automatic wait_round(input logic [3:0] r, input int lim);
        int n = 0;
        while (!(rk_valid && rk_round == r) && n < lim) begin
            tick();
            n++;
        end
        if (!(rk_valid && rk_round == r)) begin
            checks++;
            errors++;
            $display("FAIL round_timeout: round %0d never presented, rk_round=%0d", r, rk_round);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rk_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every valid cycle must show the queue head; a handshake pops it.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_pend = 1'b0;
        end else begin
            if (done_pend || done) check("done_pulse", 128'(done), 128'(done_pend));
            done_pend = 1'b0;
            if (rk_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_key", 128'(rk_round), 128'hf);
                end else begin
                    check("rk_round", 128'(rk_round), 128'(q[0].round));
                    if (q[0].chk) check("roundkey", roundkey, q[0].key);
                    if (rk_ready) begin
                        done_pend = (q[0].round == 4'd14);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int n;
        #12;
        check("rst_busy", 128'(busy), 0);
        check("rst_valid", 128'(rk_valid), 0);
        check("rst_roundkey", roundkey, 0);
        tick();
        rst_n = 1'b1;
        tick();

        push_a3();
        key = KEY_A3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r0_valid", 128'(rk_valid), 1);
        check("r0_busy", 128'(busy), 1);
        wait_done(40, n);
        check("done_latency", 128'(n), 15);
        check("done_valid_low", 128'(rk_valid), 0);
        tick();

        stall_mode = 1'b1;
        push_a3();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(400, n);
        stall_mode = 1'b0;
        tick();

        push_a3();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_round(4'd5, 40);
        key = {8{32'h11111111}};
        start = 1'b1;
        tick();
        start = 1'b0;
        key = KEY_A3;
        wait_done(40, n);
        tick();

        push_a3();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_round(4'd7, 40);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 0);
        check("arst_valid", 128'(rk_valid), 0);
        check("arst_done", 128'(done), 0);
        check("arst_round", 128'(rk_round), 0);
        check("arst_roundkey", roundkey, 0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 128'(rk_valid), 0);

        push_zero();
        key = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_r0_round", 128'(rk_round), 0);
        wait_round(4'd14, 40);
        push_a3();
        key = KEY_A3;
        start = 1'b1;
        tick();
        check("final_hs_done", 128'(done), 1);
        check("final_hs_start_ignored", 128'(rk_valid), 0);
        check("final_hs_busy", 128'(busy), 0);
        tick();
        start = 1'b0;
        check("b2b_valid", 128'(rk_valid), 1);
        check("b2b_round", 128'(rk_round), 0);
        wait_done(40, n);
        tick();
        tick();
        check("queue_drained", 128'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
